load_return_unit: RTL and testbench
===================================

// Module: load_return_unit
// PURPOSE
//  Load-side return path of the data-memory interface: captures each issued load (funct3, addr, rd),
//  selects the returning source (DMEM synchronous read data or memory-mapped UART/IO), extracts the
//  byte/half/word lane and sign/zero-extends it for writeback. Sits between execute and writeback,
//  mirroring the store-side lane masking/shifting; owns the UART RX consume handshake and load stall.
// PARAMETERS
//  IO_STATUS_OFF  4'h0   IO offset (addr[3:0]) of status word {30'b0, io_tx_ready, io_rx_valid}
//  IO_RXDATA_OFF  4'h4   IO offset of RX data word {24'b0, io_rx_data}; reading it consumes the byte
// PORTS
//  clk            in   1   system clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  req_valid      in   1   load issued this cycle (LOAD opcode in execute, not squashed)
//  req_funct3     in   3   load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  req_addr       in   32  effective byte address
//  req_rd         in   5   destination register
//  dmem_dout      in   32  DMEM read data, valid the cycle after the request
//  io_rx_valid    in   1   UART receiver holds an unread byte
//  io_rx_data     in   8   UART received byte
//  io_tx_ready    in   1   UART transmitter can accept a byte
//  io_rx_ready    out  1   one-cycle pulse: RX byte consumed
//  stall          out  1   hold upstream; request inputs must stay stable while high
//  wb_valid       out  1   wb_data/wb_rd valid this cycle (single-cycle pulse per load)
//  wb_data        out  32  aligned, extended load result
//  wb_rd          out  5   destination register of wb_data
//  load_misaligned out 1   pulse with wb_valid: LH/LHU addr[0]=1 or LW addr[1:0]!=0
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; captured funct3/addr/rd cleared.
//  - Region decode on req_addr: IO if addr[31:28]==4'b1000; DMEM if addr[31:30]==2'b00 && addr[28]==1;
//    anything else UNMAPPED.
//  - FSM IDLE -> RESP on req_valid && !stall (captures funct3, addr[3:0], region, rd).
//    RESP: wb_valid=1 (latency 1 cycle); -> RESP if new req_valid accepted same cycle, else IDLE.
//    Back-to-back loads sustain 1 load/cycle with no stall.
//  - DMEM: lane from captured addr[1:0]: LB/LBU byte addr[1:0]; LH/LHU half addr[1]; LW whole word.
//    LB/LH sign-extend bit 7/15; LBU/LHU zero-extend. Unlisted funct3 (011,110,111) treated as LW.
//  - Misaligned: wb_data=0, load_misaligned=1, wb_valid still 1; no memory side effect.
//  - UNMAPPED: wb_data=0, wb_valid=1, no error flag.
//  - IO status read: value sampled in RESP cycle. Other IO offsets return 0. Lane/extend rules apply.
//  - IO RX data read with io_rx_valid=1 in RESP: wb_data={24'b0,io_rx_data} then lane rule,
//    io_rx_ready=1 same cycle.
//  - io_rx_ready never asserts without a committed RX-data read; at most one pulse per load.
//  - Simultaneous: new req_valid in RESP cycle is accepted; stall never depends on req_valid.
//  - rst_n low mid-load: load dropped, no wb_valid, no io_rx_ready after release.
// CONFIGURATION
//  IO_BLOCKING_READ_EN defined: RX data read with io_rx_valid=0 in RESP -> state WAIT_RX, stall=1,
//   wb_valid=0; in WAIT_RX when io_rx_valid=1: wb_valid=1, io_rx_ready=1, stall=0, -> IDLE.
//  Undefined: no WAIT_RX state; such a read returns wb_data=0 in RESP, io_rx_ready=0, stall stays 0.
// STRUCTURE
//  riscv_mem_pkg: funct3 load constants, region-decode constants (IO/DMEM nibbles), IO offsets,
//   FSM state encoding {IDLE, RESP, WAIT_RX}.
//  Sub-module load_aligner (combinational): {word, addr[1:0], funct3} -> {data, misaligned};
//   shared with future cache refill path.
// TESTING
//  1. DMEM word 32'h8899AABC: LB @..01 -> FFFFFFAA; LBU @..01 -> 000000AA; LH @..10 -> FFFF8899.
//  2. LW 0x1000_0000 then LW 0x1000_0004 back-to-back -> wb_valid 2 consecutive cycles, stall=0.
//  3. LH @ 0x1000_0003 -> wb_valid=1, wb_data=0, load_misaligned=1.
//  4. LW 0x8000_0004, io_rx_valid=1, data 8'h41 -> wb_data=32'h41, io_rx_ready one pulse.
//  5. LW 0x8000_0004, io_rx_valid=0 for 3 cycles (_EN set) -> stall 3 cycles, then data + one
//     io_rx_ready pulse; _EN unset -> wb_data=0 at latency 1, no pulse.
//  6. rst_n low during WAIT_RX -> outputs 0 immediately, no wb_valid/io_rx_ready after release.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared data-memory definitions: load funct3 codes, region decode, IO offsets, FSM states.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] IO_NIBBLE   = 4'b1000;
    localparam logic [1:0] DMEM_TOP    = 2'b00;

    localparam logic [3:0] IO_STATUS_OFF = 4'h0;
    localparam logic [3:0] IO_RXDATA_OFF = 4'h4;

    typedef enum logic [1:0] {ST_IDLE, ST_RESP, ST_WAIT_RX} state_e;
    typedef enum logic [1:0] {RGN_UNMAPPED, RGN_DMEM, RGN_IO} region_e;

    function automatic region_e decode_region(input logic [31:0] addr);
        if (addr[31:28] == IO_NIBBLE)
            return RGN_IO;
        else if (addr[31:30] == DMEM_TOP && addr[28])
            return RGN_DMEM;
        else
            return RGN_UNMAPPED;
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational lane extraction and sign/zero extension of a 32-bit word for a load.
module load_aligner
    import riscv_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o,
    output logic        misaligned_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign shifted  = word_i >> {off_i, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        data_o       = '0;
        misaligned_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data_o = {24'b0, byte_sel};
            F3_LH, F3_LHU: begin
                if (off_i[0])
                    misaligned_o = 1'b1;
                else if (funct3_i == F3_LH)
                    data_o = {{16{half_sel[15]}}, half_sel};
                else
                    data_o = {16'b0, half_sel};
            end
            default: begin
                // LW and the unused encodings all behave as a full-word load.
                if (off_i != 2'b00)
                    misaligned_o = 1'b1;
                else
                    data_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/load_return_unit.sv
// Load return path: captures a load, selects DMEM/IO source, aligns and extends for writeback.
// Optional IO_BLOCKING_READ_EN: an RX-data read with no byte pending waits (stalls) for one.
module load_return_unit
    import riscv_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [4:0]  req_rd,
    input  logic [31:0] dmem_dout,
    input  logic        io_rx_valid,
    input  logic [7:0]  io_rx_data,
    input  logic        io_tx_ready,
    output logic        io_rx_ready,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        load_misaligned
);

    state_e      state_q, state_d;
    region_e     region_q;
    logic [2:0]  funct3_q;
    logic [3:0]  addr_q;
    logic [4:0]  rd_q;

    logic        accept;
    logic        rx_read;
    logic [31:0] src_word;
    logic [31:0] align_data;
    logic        align_mis;
    logic        unused_addr;

    assign unused_addr = ^req_addr[27:4];

    assign rx_read = (region_q == RGN_IO) && (addr_q[3:2] == IO_RXDATA_OFF[3:2]);

    always_comb begin
        src_word = '0;
        case (region_q)
            RGN_DMEM: src_word = dmem_dout;
            RGN_IO: begin
                if (addr_q[3:2] == IO_STATUS_OFF[3:2])
                    src_word = {30'b0, io_tx_ready, io_rx_valid};
                else if (rx_read && io_rx_valid)
                    src_word = {24'b0, io_rx_data};
            end
            default: src_word = '0;
        endcase
    end

    load_aligner u_aligner (
        .word_i       (src_word),
        .off_i        (addr_q[1:0]),
        .funct3_i     (funct3_q),
        .data_o       (align_data),
        .misaligned_o (align_mis)
    );

    always_comb begin
        stall    = 1'b0;
        wb_valid = 1'b0;
        case (state_q)
            ST_RESP: begin
`ifdef IO_BLOCKING_READ_EN
                if (rx_read && !io_rx_valid && !align_mis)
                    stall = 1'b1;
                else
                    wb_valid = 1'b1;
`else
                wb_valid = 1'b1;
`endif
            end
`ifdef IO_BLOCKING_READ_EN
            ST_WAIT_RX: begin
                if (io_rx_valid)
                    wb_valid = 1'b1;
                else
                    stall = 1'b1;
            end
`endif
            default: ;
        endcase

        accept = req_valid && !stall;
        if (accept)
            state_d = ST_RESP;
`ifdef IO_BLOCKING_READ_EN
        else if (stall)
            state_d = ST_WAIT_RX;
`endif
        else
            state_d = ST_IDLE;

        // Consume only on a committed, aligned RX-data read that actually carried a byte.
        io_rx_ready     = wb_valid && rx_read && io_rx_valid && !align_mis;
        load_misaligned = wb_valid && align_mis && (region_q != RGN_UNMAPPED);
        wb_data         = wb_valid ? align_data : 32'b0;
        wb_rd           = wb_valid ? rd_q : 5'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            region_q <= RGN_UNMAPPED;
            funct3_q <= '0;
            addr_q   <= '0;
            rd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                region_q <= decode_region(req_addr);
                funct3_q <= req_funct3;
                addr_q   <= req_addr[3:0];
                rd_q     <= req_rd;
            end
        end
    end

endmodule

// File: tb/tb_load_return_unit.sv
// Directed self-checking bench for load_return_unit; inputs change on the falling edge.
module tb_load_return_unit;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [4:0]  req_rd;
    logic [31:0] dmem_dout;
    logic        io_rx_valid;
    logic [7:0]  io_rx_data;
    logic        io_tx_ready;
    logic        io_rx_ready;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        load_misaligned;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_return_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_rd          (req_rd),
        .dmem_dout       (dmem_dout),
        .io_rx_valid     (io_rx_valid),
        .io_rx_data      (io_rx_data),
        .io_tx_ready     (io_tx_ready),
        .io_rx_ready     (io_rx_ready),
        .stall           (stall),
        .wb_valid        (wb_valid),
        .wb_data         (wb_data),
        .wb_rd           (wb_rd),
        .load_misaligned (load_misaligned)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_addr   = addr;
        req_rd     = rd;
    endtask

    task automatic wb_expect(input string tag, input logic [31:0] data, input logic [4:0] rd);
        check({tag, ".valid"}, {31'b0, wb_valid}, 32'd1);
        check({tag, ".data"}, wb_data, data);
        check({tag, ".rd"}, {27'b0, wb_rd}, {27'b0, rd});
        check({tag, ".stall"}, {31'b0, stall}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_funct3  = 3'b0;
        req_addr    = 32'b0;
        req_rd      = 5'b0;
        dmem_dout   = 32'b0;
        io_rx_valid = 1'b0;
        io_rx_data  = 8'b0;
        io_tx_ready = 1'b0;

        @(negedge clk); #1;
        check("rst.wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst.wb_data", wb_data, 32'd0);
        check("rst.wb_rd", {27'b0, wb_rd}, 32'd0);
        check("rst.stall", {31'b0, stall}, 32'd0);
        check("rst.rx_ready", {31'b0, io_rx_ready}, 32'd0);
        check("rst.misaligned", {31'b0, load_misaligned}, 32'd0);

        // Lane extraction from DMEM word 8899AABC, back-to-back loads
        @(negedge clk);
        rst_n = 1'b1;
        issue(F3_LB, 32'h1000_0001, 5'd5);
        @(negedge clk);
        dmem_dout = 32'h8899_AABC;
        issue(F3_LBU, 32'h1000_0001, 5'd6);
        #1 wb_expect("lb", 32'hFFFF_FFAA, 5'd5);
        @(negedge clk);
        issue(F3_LH, 32'h1000_0002, 5'd7);
        #1 wb_expect("lbu", 32'h0000_00AA, 5'd6);
        @(negedge clk);
        issue(F3_LW, 32'h1000_0000, 5'd8);
        #1 wb_expect("lh", 32'hFFFF_8899, 5'd7);
        @(negedge clk);
        dmem_dout = 32'h1122_3344;
        issue(F3_LW, 32'h1000_0004, 5'd9);
        #1 wb_expect("lw0", 32'h1122_3344, 5'd8);
        @(negedge clk);
        dmem_dout = 32'h5566_7788;
        issue(F3_LH, 32'h1000_0003, 5'd10);
        #1 wb_expect("lw4", 32'h5566_7788, 5'd9);
        check("lw4.misaligned", {31'b0, load_misaligned}, 32'd0);

        // Misaligned halfword
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("mis.valid", {31'b0, wb_valid}, 32'd1);
        check("mis.data", wb_data, 32'd0);
        check("mis.flag", {31'b0, load_misaligned}, 32'd1);
        @(negedge clk); #1;
        check("idle.valid", {31'b0, wb_valid}, 32'd0);
        check("idle.flag", {31'b0, load_misaligned}, 32'd0);

        // Unmapped region
        @(negedge clk);
        dmem_dout = 32'hFFFF_FFFF;
        issue(F3_LW, 32'h4000_0000, 5'd3);
        @(negedge clk);
        req_valid = 1'b0;
        #1 wb_expect("unmapped", 32'd0, 5'd3);
        check("unmapped.flag", {31'b0, load_misaligned}, 32'd0);

        // IO RX data read with byte pending
        @(negedge clk);
        io_rx_valid = 1'b1;
        io_rx_data  = 8'h41;
        issue(F3_LW, 32'h8000_0004, 5'd11);
        @(negedge clk);
        req_valid = 1'b0;
        #1 wb_expect("rx", 32'h0000_0041, 5'd11);
        check("rx.ready", {31'b0, io_rx_ready}, 32'd1);
        @(negedge clk); #1;
        check("rx.ready_once", {31'b0, io_rx_ready}, 32'd0);

        // Signed byte from RX word
        @(negedge clk);
        io_rx_data = 8'h80;
        issue(F3_LB, 32'h8000_0004, 5'd15);
        @(negedge clk);
        req_valid = 1'b0;
        #1 wb_expect("rx_lb", 32'hFFFF_FF80, 5'd15);
        check("rx_lb.ready", {31'b0, io_rx_ready}, 32'd1);

        // Status word and an unused IO offset
        @(negedge clk);
        io_rx_valid = 1'b0;
        io_tx_ready = 1'b1;
        issue(F3_LW, 32'h8000_0000, 5'd14);
        @(negedge clk);
        issue(F3_LW, 32'h8000_0008, 5'd16);
        #1 wb_expect("status", 32'h0000_0002, 5'd14);
        @(negedge clk);
        req_valid = 1'b0;
        #1 wb_expect("io_other", 32'd0, 5'd16);
        check("io_other.ready", {31'b0, io_rx_ready}, 32'd0);

        // RX data read with no byte pending
        @(negedge clk);
        issue(F3_LW, 32'h8000_0004, 5'd12);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
`ifdef IO_BLOCKING_READ_EN
        check("blk.stall1", {31'b0, stall}, 32'd1);
        check("blk.valid1", {31'b0, wb_valid}, 32'd0);
        @(negedge clk); #1;
        check("blk.stall2", {31'b0, stall}, 32'd1);
        @(negedge clk); #1;
        check("blk.stall3", {31'b0, stall}, 32'd1);
        check("blk.ready3", {31'b0, io_rx_ready}, 32'd0);
        @(negedge clk);
        io_rx_valid = 1'b1;
        io_rx_data  = 8'h5A;
        #1 wb_expect("blk.done", 32'h0000_005A, 5'd12);
        check("blk.ready", {31'b0, io_rx_ready}, 32'd1);
        @(negedge clk); #1;
        check("blk.after_valid", {31'b0, wb_valid}, 32'd0);
        check("blk.after_ready", {31'b0, io_rx_ready}, 32'd0);
        io_rx_valid = 1'b0;
`else
        wb_expect("nb", 32'd0, 5'd12);
        check("nb.ready", {31'b0, io_rx_ready}, 32'd0);
        @(negedge clk); #1;
        check("nb.after_valid", {31'b0, wb_valid}, 32'd0);
        check("nb.after_stall", {31'b0, stall}, 32'd0);
`endif

        // Reset in the middle of a load
        @(negedge clk);
        issue(F3_LW, 32'h8000_0004, 5'd13);
        @(negedge clk);
        req_valid = 1'b0;
`ifdef IO_BLOCKING_READ_EN
        #1 check("rstmid.stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
`endif
        rst_n = 1'b0;
        #1;
        check("rstmid.valid", {31'b0, wb_valid}, 32'd0);
        check("rstmid.stall0", {31'b0, stall}, 32'd0);
        check("rstmid.ready", {31'b0, io_rx_ready}, 32'd0);
        @(negedge clk);
        io_rx_valid = 1'b1;
        io_rx_data  = 8'h33;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel.valid", {31'b0, wb_valid}, 32'd0);
        check("rel.ready", {31'b0, io_rx_ready}, 32'd0);
        @(negedge clk); #1;
        check("rel2.valid", {31'b0, wb_valid}, 32'd0);
        check("rel2.ready", {31'b0, io_rx_ready}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
